// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage.
//   XLEN, RESET_PC, DEPTH : default widths, reset vector and queue depth
//   OPC_*                 : opcode field values (inst[6:2]) used by the control unit
//   fetch_state_e         : fetch sequencer states
package riscv_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam int              DEPTH    = 2;

    localparam logic [4:0] OPC_RTYPE  = 5'b01100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO used for both the instruction queue and the PC tag
// queue of the fetch stage.
//   clk_i, rst_i : clock, asynchronous active-high reset (storage cleared too)
//   push_i/data_i: write an entry (ignored when full and not popping)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the queue; wins over push/pop in the same cycle
//   data_o       : head entry
//   count_o      : number of valid entries
//   empty_o/full_o
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (do_pop) begin
                rd_q <= next_ptr(rd_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to
// instruction memory, buffers returned words and hands them to decode.
//   clk_i, rst_i                        : clock, asynchronous active-high reset
//   imem_req_valid_o/ready_i/addr_o     : request channel to instruction memory
//   imem_rsp_valid_i/data_i             : in-order responses, no backpressure
//   redirect_i, redirect_pc_i           : taken branch/jump, new fetch target
//   inst_valid_o/ready_i, inst_o        : instruction handed to decode
//   inst_pc_o                           : PC of inst_o
//   opcode_o                            : inst_o[6:2] for the control unit
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready in the same cycle, and once
// imem_req_valid_o is raised it stays high with a stable address until it is
// accepted, unless a redirect retargets the PC.
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int              DEPTH    = riscv_pkg::DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic [4:0]      opcode_o
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = 32 + XLEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;     // accepted requests awaiting a response
    logic [CW-1:0]   drop_q, drop_d;   // responses still to be discarded

    logic            accept;
    logic            rsp_keep;
    logic            inst_pop;

    logic [IW-1:0]   iq_head;
    logic [CW-1:0]   iq_count;
    logic            iq_empty;
    logic            iq_full;
    logic [XLEN-1:0] tq_head;
    logic [CW-1:0]   tq_count;
    logic            tq_empty;
    logic            tq_full;

    // Buffered plus in-flight fetches are capped at DEPTH, so every response
    // is guaranteed a free queue slot without any backpressure to memory.
    assign imem_req_valid_o = (state_q == RUN) &&
                              (({1'b0, out_q} + {1'b0, iq_count}) < (CW + 1)'(DEPTH));
    assign imem_req_addr_o  = pc_q;
    assign accept           = imem_req_valid_o && imem_req_ready_i;

    // A response in a redirect cycle belongs to the abandoned path.
    assign rsp_keep = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;

    assign inst_valid_o = !iq_empty;
    assign inst_pop     = inst_valid_o && inst_ready_i;
    assign inst_o       = iq_head[IW-1:XLEN];
    assign inst_pc_o    = iq_head[XLEN-1:0];
    assign opcode_o     = iq_head[XLEN+6:XLEN+2];

    // PC of each kept request, in issue order; popped as its response returns.
    fetch_queue #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (pc_q),
        .pop_i   (rsp_keep),
        .flush_i (redirect_i),
        .data_o  (tq_head),
        .count_o (tq_count),
        .empty_o (tq_empty),
        .full_o  (tq_full)
    );

    fetch_queue #(.WIDTH(IW), .DEPTH(DEPTH)) u_inst_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rsp_keep),
        .data_i  ({imem_rsp_data_i, tq_head}),
        .pop_i   (inst_pop),
        .flush_i (redirect_i),
        .data_o  (iq_head),
        .count_o (iq_count),
        .empty_o (iq_empty),
        .full_o  (iq_full)
    );

    always_comb begin
        state_d = RUN;
        out_d   = out_q + CW'(accept) - CW'(imem_rsp_valid_i);
        drop_d  = drop_q;
        pc_d    = pc_q;

        if (accept) begin
            pc_d = pc_q + XLEN'(4);   // wraps naturally from the top word to 0
        end

        if (redirect_i) begin
            pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
            // Everything still in flight after this edge, including a request
            // accepted right now at the old PC, must be thrown away.
            drop_d = out_d;
        end else if (imem_rsp_valid_i && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    a_push_not_full : assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_keep |-> !iq_full);
    a_tag_present : assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_keep |-> !tq_empty);
    a_tag_room : assert property (@(posedge clk_i) disable iff (rst_i)
        accept |-> !tq_full);
    a_out_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        out_q <= CW'(DEPTH));
    a_drop_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        drop_q <= CW'(DEPTH));
    a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        (iq_count <= CW'(DEPTH)) && (tq_count <= CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [4:0]  opcode_o;

    fetch_unit dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .opcode_o         (opcode_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // stimulus knobs
    logic        mem_ready;
    int          lat;
    logic        dec_ready;
    logic        redir;
    logic [31:0] redir_pc;

    // memory model: accepted requests waiting for their response cycle
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    // logs
    logic [31:0] req_log[$];
    int          acc_cyc[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_inst[$];
    logic [4:0]  dl_opc[$];
    int          dl_cyc[$];

    // Memory contents: address 0 holds an R-type add, all other words are a
    // simple address-derived pattern.
    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'h0020_81B3 : (addr ^ 32'h5A5A_0013);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory/decode/redirect from the knobs, log
    // handshakes seen this cycle, then advance to just after the edge.
    task automatic cycle_once();
        if (mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = inst_of(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
        end
        imem_req_ready_i = mem_ready;
        if (imem_req_valid_o && mem_ready) begin
            mem_addr_q.push_back(imem_req_addr_o);
            mem_due_q.push_back(cyc + lat);
            req_log.push_back(imem_req_addr_o);
            acc_cyc.push_back(cyc);
        end
        inst_ready_i = dec_ready;
        if (inst_valid_o && dec_ready) begin
            dl_pc.push_back(inst_pc_o);
            dl_inst.push_back(inst_o);
            dl_opc.push_back(opcode_o);
            dl_cyc.push_back(cyc);
        end
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        @(posedge clk);
        #1;
        cyc++;
        redir = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_once();
    endtask

    task automatic wait_reqs(input string tag, input int n, input int limit);
        int k;
        k = 0;
        while (req_log.size() < n && k < limit) begin
            cycle_once();
            k++;
        end
        check_eq(tag, req_log.size(), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, imem_req_valid_o, 1'b0);
        check_eq({tag, "_req_addr"}, imem_req_addr_o, 32'h0);
        check_eq({tag, "_inst_valid"}, inst_valid_o, 1'b0);
        check_eq({tag, "_inst"}, inst_o, 32'h0);
        check_eq({tag, "_inst_pc"}, inst_pc_o, 32'h0);
        check_eq({tag, "_opcode"}, opcode_o, 5'h0);
    endtask

    // Holds reset for two edges, clears the bench model, releases reset just
    // after an edge. The DUT is then in its BOOT cycle.
    task automatic do_reset();
        rst_i            = 1'b1;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        inst_ready_i     = 1'b0;
        mem_ready        = 1'b1;
        lat              = 1;
        dec_ready        = 1'b1;
        redir            = 1'b0;
        redir_pc         = '0;
        mem_addr_q.delete();
        mem_due_q.delete();
        req_log.delete();
        acc_cyc.delete();
        dl_pc.delete();
        dl_inst.delete();
        dl_opc.delete();
        dl_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    task automatic check_boot(input string tag);
        check_eq({tag, "_boot_valid"}, imem_req_valid_o, 1'b0);
        cycle_once();
        check_eq({tag, "_run_valid"}, imem_req_valid_o, 1'b1);
        check_eq({tag, "_run_addr"}, imem_req_addr_o, 32'h0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst_i            = 1'b1;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        inst_ready_i     = 1'b0;
        mem_ready        = 1'b1;
        lat              = 1;
        dec_ready        = 1'b1;
        redir            = 1'b0;
        redir_pc         = '0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst0");

        // Test 1: streaming, L=1, decode always ready
        do_reset();
        check_boot("t1");
        run(20);
        check_eq("t1_nreq", req_log.size() >= 3, 1'b1);
        check_eq("t1_ndl", dl_pc.size() >= 3, 1'b1);
        if (req_log.size() >= 3) begin
            check_eq("t1_req0", req_log[0], 32'h0);
            check_eq("t1_req1", req_log[1], 32'h4);
            check_eq("t1_req2", req_log[2], 32'h8);
        end
        if (dl_pc.size() >= 3) begin
            check_eq("t1_pc0", dl_pc[0], 32'h0);
            check_eq("t1_pc1", dl_pc[1], 32'h4);
            check_eq("t1_pc2", dl_pc[2], 32'h8);
            check_eq("t1_inst0", dl_inst[0], 32'h0020_81B3);
            check_eq("t1_inst1", dl_inst[1], 32'h5A5A_0017);
            check_eq("t1_inst2", dl_inst[2], 32'h5A5A_001B);
            check_eq("t1_opc0", dl_opc[0], 5'b01100);
            check_eq("t1_latency", dl_cyc[0] - acc_cyc[0], 2);
        end

        // Test 2: decode stalled -> queue fills, requests stop at 2
        do_reset();
        dec_ready = 1'b0;
        check_boot("t2");
        run(8);
        check_eq("t2_valid", inst_valid_o, 1'b1);
        check_eq("t2_head_pc", inst_pc_o, 32'h0);
        check_eq("t2_head_inst", inst_o, 32'h0020_81B3);
        check_eq("t2_head_opc", opcode_o, 5'b01100);
        check_eq("t2_req_stop", imem_req_valid_o, 1'b0);
        check_eq("t2_nreq", req_log.size(), 2);
        dec_ready = 1'b1;
        run(10);
        check_eq("t2_ndl", dl_pc.size() >= 2 && req_log.size() >= 3, 1'b1);
        if (dl_pc.size() >= 2 && req_log.size() >= 3) begin
            check_eq("t2_pc0", dl_pc[0], 32'h0);
            check_eq("t2_pc1", dl_pc[1], 32'h4);
            check_eq("t2_resume", req_log[2], 32'h8);
        end

        // Test 3: two outstanding (L=3), redirect to 0x100
        do_reset();
        lat = 3;
        check_boot("t3");
        wait_reqs("t3_wait", 2, 20);
        redir    = 1'b1;
        redir_pc = 32'h0000_0100;
        cycle_once();
        check_eq("t3_newpc", imem_req_addr_o, 32'h100);
        check_eq("t3_flushed", inst_valid_o, 1'b0);
        run(15);
        check_eq("t3_ndl", dl_pc.size() >= 1 && req_log.size() >= 3, 1'b1);
        if (dl_pc.size() >= 1 && req_log.size() >= 3) begin
            check_eq("t3_req2", req_log[2], 32'h100);
            check_eq("t3_pc0", dl_pc[0], 32'h100);
            check_eq("t3_inst0", dl_inst[0], 32'h5A5A_0113);
        end

        // Test 4: redirect to 0x103 alongside a response and an accept
        do_reset();
        lat = 1;
        check_boot("t4");
        wait_reqs("t4_wait", 1, 20);
        redir    = 1'b1;
        redir_pc = 32'h0000_0103;
        cycle_once();
        check_eq("t4_accept_in_redir", req_log.size(), 2);
        check_eq("t4_newpc", imem_req_addr_o, 32'h100);
        check_eq("t4_flushed", inst_valid_o, 1'b0);
        run(12);
        check_eq("t4_ndl", dl_pc.size() >= 2 && req_log.size() >= 3, 1'b1);
        if (dl_pc.size() >= 2 && req_log.size() >= 3) begin
            check_eq("t4_req2", req_log[2], 32'h100);
            check_eq("t4_pc0", dl_pc[0], 32'h100);
            check_eq("t4_pc1", dl_pc[1], 32'h104);
            check_eq("t4_inst0", dl_inst[0], 32'h5A5A_0113);
        end

        // Test 5: PC wrap at the top of the address space
        do_reset();
        redir    = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        cycle_once();
        run(10);
        check_eq("t5_n", dl_pc.size() >= 2 && req_log.size() >= 2, 1'b1);
        if (dl_pc.size() >= 2 && req_log.size() >= 2) begin
            check_eq("t5_req0", req_log[0], 32'hFFFF_FFFC);
            check_eq("t5_req1", req_log[1], 32'h0);
            check_eq("t5_pc0", dl_pc[0], 32'hFFFF_FFFC);
            check_eq("t5_inst0", dl_inst[0], 32'hA5A5_FFEF);
            check_eq("t5_pc1", dl_pc[1], 32'h0);
            check_eq("t5_inst1", dl_inst[1], 32'h0020_81B3);
        end

        // Test 6: asynchronous reset mid-stream with a full queue
        do_reset();
        dec_ready = 1'b0;
        check_boot("t6");
        run(8);
        check_eq("t6_pre_valid", inst_valid_o, 1'b1);
        check_eq("t6_pre_addr", imem_req_addr_o, 32'h8);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        do_reset();
        check_boot("t6_post");
        run(6);
        check_eq("t6_ndl", dl_pc.size() >= 1, 1'b1);
        if (dl_pc.size() >= 1) begin
            check_eq("t6_pc0", dl_pc[0], 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of decode and the control unit.
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a 2-entry queue and presents them to decode over a valid/ready handshake.
- Exports opcode_o (instruction[6:2]) for the control unit.
- Handles branch redirects by flushing the queue and discarding in-flight responses.

Parameters:
XLEN, 32, width of PC and instruction words
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, instruction queue entries; also the cap on outstanding plus buffered fetches

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  XLEN  fetch address (= PC)
imem_rsp_valid_i  in  1  response valid, in order, one per accepted request, no backpressure
imem_rsp_data_i  in  32  instruction word
redirect_i  in  1  branch/jump taken; load new PC
redirect_pc_i  in  XLEN  redirect target
inst_valid_o  out  1  instruction available to decode
inst_ready_i  in  1  decode consumes instruction
inst_o  out  32  instruction word
inst_pc_o  out  XLEN  PC of inst_o
opcode_o  out  5  inst_o[6:2], to control unit

Behaviour:
- Reset (async, any time): PC=RESET_PC, state=BOOT, queue empty, outstanding=0, drop=0.
  - All outputs are 0 while reset is asserted; imem_req_addr_o=RESET_PC.
  - The memory is reset by the same rst_i; no response arrives for pre-reset requests.
- FSM:
  - BOOT: imem_req_valid_o=0; go to RUN after one cycle.
  - RUN: normal operation. There is no other state.
- Request issue in RUN: imem_req_valid_o = (outstanding + count < DEPTH), registered-input combinational.
  - outstanding counts every accepted request awaiting response, including ones to be dropped.
  - On handshake (valid & ready), PC += 4; wrap 32'hFFFF_FFFC -> 0.
  - A request is never withdrawn once asserted, except by redirect.
- Response:
  - If drop>0: discard and decrement drop.
  - Otherwise push {data, pc} into the queue. The PC tag is taken from a matching tag queue written at request accept.
  - The issue rule guarantees the queue is never full on push. A push while full is an assertion failure.
- Latency: request accepted in cycle N, response in cycle N+L (L≥1), inst_valid_o high in cycle N+L+1. There is no response-to-output bypass.
- Decode handshake:
  - inst_valid_o = queue not empty. inst_o, inst_pc_o and opcode_o are the head entry.
  - Pop on inst_valid_o & inst_ready_i.
  - Push and pop in the same cycle are allowed when count≥1; count is unchanged.
- Redirect (redirect_i=1 at edge):
  - PC <= {redirect_pc_i[XLEN-1:2], 2'b00}; low bits are ignored.
  - Queue and tag queue are cleared; inst_valid_o=0 next cycle.
  - drop <= outstanding after this edge's accept/return updates. This includes a request accepted in the redirect cycle, at the old PC.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is considered done; the entry is discarded either way.
  - imem_req_valid_o may stay high in the redirect cycle with the old address.
  - Next cycle, requests resume from the new PC, subject to the issue rule.
- Back-to-back redirects: the second overrides the first and drop is recomputed. Total responses discarded equals all accepted requests before the last redirect edge.
- Counter widths: outstanding, drop and count are $clog2(DEPTH+1) bits. They must never exceed DEPTH; this is asserted.

Decomposition:
- Shared package riscv_pkg: XLEN, RESET_PC, opcode constants (OPC_RTYPE=5'b01100, OPC_LOAD=5'b00000, OPC_STORE=5'b01000, OPC_BRANCH=5'b11000), fetch state enum {BOOT, RUN}.
- Sub-module fetch_queue: DEPTH-entry synchronous FIFO with width parameter, push/pop/flush, count, empty/full. It is instantiated twice: once for instruction+PC, once for the PC tag of outstanding requests.

Test Plan:
- Reset release with memory always ready, L=1, decode always ready -> addresses 0,4,8,… issued from cycle 2; inst_pc_o sequence 0,4,8; opcode_o=5'b01100 for inst 32'h0020_81B3.
- Decode ready held low -> queue fills to 2, imem_req_valid_o drops after 2 outstanding+buffered. Release ready -> instructions 0,4 delivered in order, fetch resumes at 8.
- Two requests outstanding (L=3), redirect_i with redirect_pc_i=32'h100 -> both old responses discarded, first delivered inst_pc_o=32'h100.
- Redirect with redirect_pc_i=32'h103 in the same cycle as a response and an accepted request -> both in-flight responses dropped, next fetch address 32'h100.
- PC at 32'hFFFF_FFFC -> next request address 32'h0000_0000.
- rst_i asserted mid-stream with queue full -> all outputs 0 immediately (async). After release, one BOOT cycle, then fetch from RESET_PC.
